dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter DEPTH_WORDS, default 4096: number of 32-bit words in the data array.
REQ-002 Parameter WAIT_STATES, default 0: extra access cycles inserted per request, range 0..15.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  controller can accept a request.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned.
REQ-010 req_size  input  2  access size: 0 = byte, 1 = half, 2 = word; 3 is reserved.
REQ-011 req_unsigned  input  1  zero-extend loads when 1; sign-extend when 0.
REQ-012 resp_valid  output  1  response present.
REQ-013 resp_ready  input  1  consumer accepts the response.
REQ-014 resp_rdata  output  32  load result; 0 for stores and errors.
REQ-015 resp_err  output  1  request faulted: misaligned, out of range, or reserved size.

Function
REQ-016 FSM states SHALL be IDLE, ACCESS and RESP; req_ready SHALL be 1 only in IDLE.
REQ-017 Acceptance SHALL occur when req_valid && req_ready at a rising edge; all request fields are captured at that edge, and the state moves IDLE->ACCESS.
REQ-018 ACCESS SHALL last exactly 1+WAIT_STATES cycles, timed by a down-counter, then move to RESP.
REQ-019 For a request accepted at edge k, resp_valid SHALL first be high in the cycle after edge k+1+WAIT_STATES.
REQ-020 In RESP, resp_valid, resp_rdata and resp_err SHALL be held stable until resp_valid && resp_ready at an edge, which moves the state to IDLE.
REQ-021 A new request SHALL be accepted no earlier than the cycle after response completion, giving no overlap and one outstanding request at most.
REQ-022 Word index SHALL be req_addr[31:2] and lane SHALL be req_addr[1:0].
REQ-023 A request SHALL fault under any of these conditions:
- size 1 with addr[0]=1;
- size 2 with addr[1:0]!=0;
- size 3;
- word index >= DEPTH_WORDS.
REQ-024 A faulting request SHALL keep normal latency, assert resp_err=1 and resp_rdata=0, and make no array write.
REQ-025 Stores SHALL write only the addressed lanes, with byte enables 0001<<lane, 0011<<lane or 1111, and data replicated into those lanes; other bytes SHALL be unchanged.
REQ-026 The store SHALL commit at the final ACCESS edge, the ACCESS->RESP transition.
REQ-027 Loads SHALL read the word synchronously during ACCESS, extract the lane byte or half, and extend it per req_unsigned.
REQ-028 Store responses SHALL return resp_rdata=0 and resp_err=0.
REQ-029 A store followed by a load to the same word SHALL return the updated data.

Reset
REQ-030 While rst=1 at an edge, the state SHALL go to IDLE, the wait counter to 0, resp_valid to 0, resp_rdata to 0 and resp_err to 0; req_ready SHALL be 1 in the cycle after rst deasserts.
REQ-031 Reset SHALL take priority over every other event; a store whose commit edge coincides with rst=1 SHALL NOT be written.
REQ-032 Reset during ACCESS or RESP SHALL discard the pending request and response.
REQ-033 Array contents SHALL NOT be cleared by reset.

Structure
REQ-034 Package dmem_pkg SHALL hold the size encodings SZ_B, SZ_H and SZ_W and the FSM state enum.
REQ-035 One combinational sub-module, dmem_lane_align, SHALL generate store byte enables and lane data, and perform load extraction and extension.
REQ-036 The array SHALL be inferred inside dmem_ctrl as DEPTH_WORDS x 32 with a per-byte write enable.

Verification
REQ-037 WAIT_STATES=0: store word 0xDEADBEEF to 0x10, then load word from 0x10 -> rdata 0xDEADBEEF, err 0; resp_valid 1 cycle after the accept edge.
REQ-038 Store byte 0x80 to 0x11, then load byte 0x11 signed -> 0xFFFFFF80; unsigned -> 0x00000080; load word 0x10 -> 0xDEAD80EF.
REQ-039 Half load from 0x13, word load from 0x12, and size 3 -> each gives err 1 and rdata 0; a following word load from 0x10 is unchanged.
REQ-040 WAIT_STATES=3: hold resp_ready=0 for 5 cycles -> resp_valid, resp_rdata and resp_err stay stable and req_ready stays 0; resp_valid first high 4 cycles after acceptance.
REQ-041 Assert rst on the final ACCESS cycle of a store of 0x12345678 to 0x20 -> word 0x20 keeps its old value; req_ready=1 in the cycle after rst deasserts.
REQ-042 Word load at byte address 4*DEPTH_WORDS -> err 1, rdata 0, normal latency.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory controller.
// Access sizes and controller FSM states.
package dmem_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Lane steering for the data memory: store byte enables and
// replicated store data, load extraction and extension.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  lane_i,
    input  logic        uns_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wlane_o,
    output logic [31:0] rdata_o
);

    logic [31:0] sh;

    assign sh = rword_i >> {lane_i, 3'b000};

    always_comb begin
        be_o    = 4'b0000;
        wlane_o = wdata_i;
        rdata_o = 32'h0;
        unique case (1'b1)
            (size_i == SZ_B): begin
                be_o    = 4'b0001 << lane_i;
                wlane_o = {4{wdata_i[7:0]}};
                rdata_o = uns_i ? {24'h0, sh[7:0]}
                                : {{24{sh[7]}}, sh[7:0]};
            end
            (size_i == SZ_H): begin
                be_o    = 4'b0011 << lane_i;
                wlane_o = {2{wdata_i[15:0]}};
                rdata_o = uns_i ? {16'h0, sh[15:0]}
                                : {{16{sh[15]}}, sh[15:0]};
            end
            (size_i == SZ_W): begin
                be_o    = 4'b1111;
                rdata_o = rword_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Single-outstanding data-memory controller with a
// configurable number of wait states and fault detection.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [29:0] DEPTH30 = 30'(DEPTH_WORDS);

    logic [31:0] mem [DEPTH_WORDS];

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, uns_q;
    logic [31:0] addr_q, wdata_q;
    logic [1:0]  size_q;
    logic [31:0] resp_rdata_q;
    logic        resp_err_q;

    logic        accept;
    logic        fault;
    logic        final_acc;
    logic [AW-1:0] idx;
    logic [31:0] rword;
    logic [3:0]  be;
    logic [31:0] wlane;
    logic [31:0] ld_data;

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

    assign accept    = req_valid && req_ready;
    assign final_acc = (state_q == ACCESS) && (cnt_q == 4'd0);
    assign idx       = addr_q[AW+1:2];
    assign rword     = mem[idx];

    always_comb begin
        fault = 1'b0;
        unique case (1'b1)
            (size_q == SZ_B): fault = 1'b0;
            (size_q == SZ_H): fault = addr_q[0];
            (size_q == SZ_W): fault = |addr_q[1:0];
            default:          fault = 1'b1;
        endcase
        if (addr_q[31:2] >= DEPTH30) begin
            fault = 1'b1;
        end
    end

    dmem_lane_align u_align (
        .size_i  (size_q),
        .lane_i  (addr_q[1:0]),
        .uns_i   (uns_q),
        .wdata_i (wdata_q),
        .rword_i (rword),
        .be_o    (be),
        .wlane_o (wlane),
        .rdata_o (ld_data)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = ACCESS;
                    cnt_d   = 4'(WAIT_STATES);
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (final_acc) begin
                resp_rdata_q <= (fault || we_q) ? 32'h0 : ld_data;
                resp_err_q   <= fault;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
        end
    end

    // Store commits on the ACCESS->RESP edge; reset blocks it
    always_ff @(posedge clk) begin
        if (!rst && final_acc && we_q && !fault) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wlane[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: one instance with no wait
// states and one with three, sharing request fields.
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        we, uns;
    logic [31:0] addr, wdata;
    logic [1:0]  size;

    logic        v0, v3, rr0, rr3;
    logic        rdy0, rdy3, rv0, rv3, er0, er3;
    logic [31:0] rd0, rd3;

    int ncmp = 0;
    int nfail = 0;

    logic [31:0] r;
    logic        e;

    always #5 clk = ~clk;

    dmem_ctrl #(.DEPTH_WORDS(4096), .WAIT_STATES(0)) dut0 (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (v0),
        .req_ready    (rdy0),
        .req_we       (we),
        .req_addr     (addr),
        .req_wdata    (wdata),
        .req_size     (size),
        .req_unsigned (uns),
        .resp_valid   (rv0),
        .resp_ready   (rr0),
        .resp_rdata   (rd0),
        .resp_err     (er0)
    );

    dmem_ctrl #(.DEPTH_WORDS(4096), .WAIT_STATES(3)) dut3 (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (v3),
        .req_ready    (rdy3),
        .req_we       (we),
        .req_addr     (addr),
        .req_wdata    (wdata),
        .req_size     (size),
        .req_unsigned (uns),
        .resp_valid   (rv3),
        .resp_ready   (rr3),
        .resp_rdata   (rd3),
        .resp_err     (er3)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic xact(input bit sel, input logic w,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] sz, input logic u,
                        input int hold,
                        output logic [31:0] rdo, output logic eo);
        int n;
        int ws;
        logic [31:0] r0;
        logic e0;
        ws = sel ? 3 : 0;
        @(negedge clk);
        we = w; addr = a; wdata = wd; size = sz; uns = u;
        chk("req_ready_idle", sel ? rdy3 : rdy0, 1);
        if (sel) v3 = 1'b1; else v0 = 1'b1;
        @(posedge clk);
        #1;
        v0 = 1'b0;
        v3 = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(sel ? rv3 : rv0) && n < 20);
        chk("latency", n, ws + 2);
        r0 = sel ? rd3 : rd0;
        e0 = sel ? er3 : er0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", sel ? rv3 : rv0, 1);
            chk("hold_rdata", sel ? rd3 : rd0, r0);
            chk("hold_err", sel ? er3 : er0, e0);
            chk("hold_ready", sel ? rdy3 : rdy0, 0);
        end
        if (sel) rr3 = 1'b1; else rr0 = 1'b1;
        @(posedge clk);
        #1;
        rr0 = 1'b0;
        rr3 = 1'b0;
        @(negedge clk);
        chk("post_valid", sel ? rv3 : rv0, 0);
        chk("post_ready", sel ? rdy3 : rdy0, 1);
        rdo = r0;
        eo  = e0;
    endtask

    initial begin
        rst = 1'b1;
        we = 0; uns = 0; addr = 0; wdata = 0; size = 0;
        v0 = 0; v3 = 0; rr0 = 0; rr3 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", rdy0, 1);
        chk("rst_valid", rv0, 0);
        chk("rst_rdata", rd0, 32'h0);
        chk("rst_err", er0, 0);
        chk("rst_valid3", rv3, 0);
        rst = 1'b0;

        xact(0, 1, 32'h10, 32'hDEADBEEF, 2'd2, 0, 0, r, e);
        chk("st_w_rdata", r, 32'h0);
        chk("st_w_err", e, 0);
        xact(0, 0, 32'h10, 32'h0, 2'd2, 0, 0, r, e);
        chk("ld_w_rdata", r, 32'hDEADBEEF);
        chk("ld_w_err", e, 0);

        xact(0, 1, 32'h11, 32'h00000080, 2'd0, 0, 0, r, e);
        chk("st_b_err", e, 0);
        xact(0, 0, 32'h11, 32'h0, 2'd0, 0, 0, r, e);
        chk("ld_b_signed", r, 32'hFFFFFF80);
        xact(0, 0, 32'h11, 32'h0, 2'd0, 1, 0, r, e);
        chk("ld_b_unsigned", r, 32'h00000080);
        xact(0, 0, 32'h10, 32'h0, 2'd2, 0, 0, r, e);
        chk("ld_w_merged", r, 32'hDEAD80EF);

        xact(0, 0, 32'h13, 32'h0, 2'd1, 0, 0, r, e);
        chk("mis_h_err", e, 1);
        chk("mis_h_rdata", r, 32'h0);
        xact(0, 0, 32'h12, 32'h0, 2'd2, 0, 0, r, e);
        chk("mis_w_err", e, 1);
        chk("mis_w_rdata", r, 32'h0);
        xact(0, 0, 32'h10, 32'h0, 2'd3, 0, 0, r, e);
        chk("sz3_err", e, 1);
        chk("sz3_rdata", r, 32'h0);
        xact(0, 1, 32'h12, 32'h11111111, 2'd2, 0, 0, r, e);
        chk("mis_st_err", e, 1);
        xact(0, 0, 32'h10, 32'h0, 2'd2, 0, 0, r, e);
        chk("ld_w_unchanged", r, 32'hDEAD80EF);
        chk("ld_w_unch_err", e, 0);

        xact(0, 1, 32'h12, 32'h1234CAFE, 2'd1, 0, 0, r, e);
        chk("st_h_err", e, 0);
        xact(0, 0, 32'h10, 32'h0, 2'd2, 0, 0, r, e);
        chk("ld_w_half", r, 32'hCAFE80EF);
        xact(0, 0, 32'h12, 32'h0, 2'd1, 0, 0, r, e);
        chk("ld_h_signed", r, 32'hFFFFCAFE);
        xact(0, 0, 32'h10, 32'h0, 2'd1, 1, 0, r, e);
        chk("ld_h_unsigned", r, 32'h000080EF);

        xact(0, 0, 32'h4000, 32'h0, 2'd2, 0, 0, r, e);
        chk("oor_err", e, 1);
        chk("oor_rdata", r, 32'h0);

        xact(1, 1, 32'h20, 32'hA5A5A5A5, 2'd2, 0, 0, r, e);
        chk("ws3_st_err", e, 0);
        xact(1, 0, 32'h20, 32'h0, 2'd2, 0, 5, r, e);
        chk("ws3_ld_rdata", r, 32'hA5A5A5A5);
        chk("ws3_ld_err", e, 0);

        @(negedge clk);
        we = 1; addr = 32'h20; wdata = 32'h12345678;
        size = 2'd2; uns = 0;
        v3 = 1'b1;
        @(posedge clk);
        #1;
        v3 = 1'b0;
        repeat (4) @(negedge clk);
        chk("acc_ready", rdy3, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready", rdy3, 1);
        chk("rst_mid_valid", rv3, 0);
        chk("rst_mid_rdata", rd3, 32'h0);
        chk("rst_mid_err", er3, 0);
        xact(1, 0, 32'h20, 32'h0, 2'd2, 0, 0, r, e);
        chk("rst_no_write", r, 32'hA5A5A5A5);
        xact(0, 0, 32'h10, 32'h0, 2'd2, 0, 0, r, e);
        chk("rst_keeps_mem", r, 32'hCAFE80EF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nfail);
        $finish;
    end

endmodule
